// File: rtl/arb_mux_pkg.sv
// Shared constants, types and helpers for the 4-to-1 arbitrated output mux.
// Read by arb_mux_4to1, its interface and the rr_arbiter_4 grant logic.
package arb_mux_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Index of the set bit of a one-hot grant; an all-zero grant gives 0.
    function automatic sel_t onehotToSel(input logic [CH_NUM-1:0] oneHot);
        sel_t sel;
        sel = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (oneHot[k]) begin
                sel = sel_t'(k);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/arb_mux_4to1_if.sv
// Handshake bundle between four source channels, the arbitrated mux and its sink.
// The master side drives the sources and the sink ready; the slave side is the mux.
interface arb_mux_4to1_if
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 16
);

    logic [WIDTH-1:0]  i0;
    logic [WIDTH-1:0]  i1;
    logic [WIDTH-1:0]  i2;
    logic [WIDTH-1:0]  i3;
    logic [CH_NUM-1:0] i_valid;
    logic [CH_NUM-1:0] i_ready;
    logic [WIDTH-1:0]  o;
    sel_t              o_sel;
    logic              o_valid;
    logic              o_ready;

    modport master (
        output i0, i1, i2, i3, i_valid, o_ready,
        input  i_ready, o, o_sel, o_valid
    );

    modport slave (
        input  i0, i1, i2, i3, i_valid, o_ready,
        output i_ready, o, o_sel, o_valid
    );

endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way grant logic producing a one-hot grant, gated by en.
// ARB_MUX_RR_EN selects round-robin from ptr+1; otherwise fixed priority ch0 > ch3.
module rr_arbiter_4
    import arb_mux_pkg::*;
(
    input  logic [CH_NUM-1:0] req,
    input  sel_t              ptr,
    input  logic              en,
    output logic [CH_NUM-1:0] gnt
);

`ifdef ARB_MUX_RR_EN
    // Search starts just after the last winner; offset CH_NUM wraps back onto ptr itself.
    always_comb begin
        sel_t idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= CH_NUM; off++) begin
            idx = ptr + sel_t'(off);
            if (en && req[idx] && !found) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    logic unusedPtrBits;
    assign unusedPtrBits = ^ptr;

    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (en && req[k] && !found) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/arb_mux_4to1.sv
// Arbitrates four valid/ready source channels into a one-entry output register.
// Define ARB_MUX_RR_EN for round-robin grants; the default build is fixed priority.
module arb_mux_4to1
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           rst,
    arb_mux_4to1_if.slave bus
);

    state_e            stateQ, stateD;
    logic [WIDTH-1:0]  dataQ, dataD;
    sel_t              selQ, selD;
    logic [WIDTH-1:0]  winData;
    sel_t              winSel;
    sel_t              ptr;
    logic [CH_NUM-1:0] gnt;
    logic              loadable;
    logic              en;

    // The register can take a word when empty or when its word drains this cycle.
    assign loadable = (stateQ == EMPTY) || bus.o_ready;
    assign en       = loadable && !rst;

    rr_arbiter_4 u_arbiter (
        .req (bus.i_valid),
        .ptr (ptr),
        .en  (en),
        .gnt (gnt)
    );

    assign bus.i_ready = gnt;
    assign winSel      = onehotToSel(gnt);

    always_comb begin
        winData = bus.i0;
        case (winSel)
            2'd0:    winData = bus.i0;
            2'd1:    winData = bus.i1;
            2'd2:    winData = bus.i2;
            default: winData = bus.i3;
        endcase
    end

    always_comb begin
        stateD = stateQ;
        dataD  = dataQ;
        selD   = selQ;
        if (|gnt) begin
            stateD = FULL;
            dataD  = winData;
            selD   = winSel;
        end else if ((stateQ == FULL) && bus.o_ready) begin
            stateD = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= EMPTY;
            dataQ  <= '0;
            selQ   <= '0;
        end else begin
            stateQ <= stateD;
            dataQ  <= dataD;
            selQ   <= selD;
        end
    end

`ifdef ARB_MUX_RR_EN
    sel_t ptrQ, ptrD;

    // Pointer remembers the last granted channel and moves only on an input transfer.
    assign ptrD = (|gnt) ? winSel : ptrQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptrQ <= 2'b11;
        end else begin
            ptrQ <= ptrD;
        end
    end

    assign ptr = ptrQ;
`else
    assign ptr = 2'b11;
`endif

    assign bus.o       = dataQ;
    assign bus.o_sel   = selQ;
    assign bus.o_valid = (stateQ == FULL);

endmodule

// File: tb/tb_arb_mux_4to1.sv
// Scoreboard bench for arb_mux_4to1: a driver predicts grants from a behavioural model,
// a separate monitor checks every word the output register presents.
module tb_arb_mux_4to1;

    typedef struct {
        int          sel;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    exp_t expQ[$];
    logic modelFull;
    int   modelPtr;

    arb_mux_4to1_if #(.WIDTH(16)) bus ();

    arb_mux_4to1 #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference grant choice: scan channels in priority order, first requester wins.
    function automatic int pickWinner(input logic [3:0] valid, input int lastGrant);
        int k;
        for (int off = 1; off <= 4; off++) begin
`ifdef ARB_MUX_RR_EN
            k = (lastGrant + off) % 4;
`else
            k = off - 1;
`endif
            if (valid[k]) begin
                return k;
            end
        end
        return -1;
    endfunction

    // One clock cycle of stimulus: drive, check i_ready, predict, then commit the model.
    task automatic applyStimulus(input logic rstV, input logic [3:0] valid, input logic readyV,
                                 input logic [15:0] d0, input logic [15:0] d1,
                                 input logic [15:0] d2, input logic [15:0] d3);
        logic [15:0] dIn[4];
        int          win;
        logic [3:0]  expReady;
        logic        nextFull;
        int          nextPtr;
        exp_t        e;
        @(negedge clk);
        rst         = rstV;
        bus.i0      = d0;
        bus.i1      = d1;
        bus.i2      = d2;
        bus.i3      = d3;
        bus.i_valid = valid;
        bus.o_ready = readyV;
        dIn[0] = d0;
        dIn[1] = d1;
        dIn[2] = d2;
        dIn[3] = d3;
        #1;
        win = (!rstV && (!modelFull || readyV)) ? pickWinner(valid, modelPtr) : -1;
        expReady = (win >= 0) ? (4'b0001 << win) : 4'b0000;
        checkOutput("i_ready", 32'(bus.i_ready), 32'(expReady));
        nextFull = modelFull;
        nextPtr  = modelPtr;
        if (rstV) begin
            nextFull = 1'b0;
            nextPtr  = 3;
        end else if (win >= 0) begin
            e.sel  = win;
            e.data = dIn[win];
            expQ.push_back(e);
            nextFull = 1'b1;
            nextPtr  = win;
        end else if (modelFull && readyV) begin
            nextFull = 1'b0;
        end
        @(posedge clk);
        #1;
        modelFull = nextFull;
        modelPtr  = nextPtr;
        if (rstV) begin
            expQ.delete();
            checkOutput("reset_o", 32'(bus.o), 32'h0);
            checkOutput("reset_o_sel", 32'(bus.o_sel), 32'h0);
        end
    endtask

    // Monitor: compares the presented word against the scoreboard head every cycle.
    initial begin
        exp_t head;
        forever begin
            @(negedge clk);
            #2;
            checkOutput("o_valid", 32'(bus.o_valid), 32'(modelFull));
            if (modelFull) begin
                if (expQ.size() == 0) begin
                    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h1);
                end else begin
                    head = expQ[0];
                    checkOutput("o_data", 32'(bus.o), 32'(head.data));
                    checkOutput("o_sel", 32'(bus.o_sel), 32'(head.sel));
                    if (bus.o_ready) begin
                        void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        checks      = 0;
        failures    = 0;
        modelFull   = 1'b0;
        modelPtr    = 3;
        rst         = 1'b1;
        bus.i0      = '0;
        bus.i1      = '0;
        bus.i2      = '0;
        bus.i3      = '0;
        bus.i_valid = '0;
        bus.o_ready = 1'b0;

        $display("[TB] reset with all channels requesting");
        applyStimulus(1'b1, 4'b1111, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        applyStimulus(1'b1, 4'b1111, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

        $display("[TB] single word on ch1");
        applyStimulus(1'b0, 4'b0010, 1'b1, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 4'b0000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 4'b0000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        $display("[TB] all channels requesting, sink always ready");
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b0, 4'b1111, 1'b1, 16'(n), 16'(1 + n), 16'(2 + n), 16'(3 + n));
        end
        applyStimulus(1'b0, 4'b0000, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);

        $display("[TB] back-pressure on a held word");
        applyStimulus(1'b0, 4'b0001, 1'b0, 16'h1234, 16'h0, 16'h0, 16'h0);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 4'b1111, 1'b0, 16'hA000, 16'hA001, 16'hA002, 16'hA003);
        end
        applyStimulus(1'b0, 4'b1111, 1'b1, 16'hB000, 16'hB001, 16'hB002, 16'hB003);
        applyStimulus(1'b0, 4'b0000, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);

        $display("[TB] pointer wrap and skip");
        applyStimulus(1'b0, 4'b0100, 1'b1, 16'hC000, 16'hC001, 16'hC002, 16'hC003);
        applyStimulus(1'b0, 4'b1001, 1'b1, 16'hD000, 16'hD001, 16'hD002, 16'hD003);
        applyStimulus(1'b0, 4'b1001, 1'b1, 16'hE000, 16'hE001, 16'hE002, 16'hE003);
        applyStimulus(1'b0, 4'b0101, 1'b1, 16'hF000, 16'hF001, 16'hF002, 16'hF003);
        applyStimulus(1'b0, 4'b0000, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);

        $display("[TB] reset while holding a word");
        applyStimulus(1'b0, 4'b1111, 1'b0, 16'h5550, 16'h5551, 16'h5552, 16'h5553);
        applyStimulus(1'b1, 4'b1111, 1'b0, 16'h6660, 16'h6661, 16'h6662, 16'h6663);
        applyStimulus(1'b0, 4'b1111, 1'b1, 16'h7770, 16'h7771, 16'h7772, 16'h7773);
        applyStimulus(1'b0, 4'b1111, 1'b1, 16'h8880, 16'h8881, 16'h8882, 16'h8883);
        applyStimulus(1'b0, 4'b0000, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          4'($urandom()),
                          ($urandom_range(0, 3) != 0),
                          16'($urandom()), 16'($urandom()),
                          16'($urandom()), 16'($urandom()));
        end

        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_mux_4to1.md
ARB_MUX_4TO1 -- requirements
Module: arb_mux_4to1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of every channel.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge triggered.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have ports i0..i3, input, WIDTH each, source channel data.
REQ-005 The block SHALL have port i_valid, input, 4, where bit k means channel k holds a word.
REQ-006 The block SHALL have port i_ready, output, 4, where bit k means channel k is accepted this cycle.
REQ-007 The block SHALL have port o, output, WIDTH, the merged output data.
REQ-008 The block SHALL have port o_sel, output, 2, the index of the source channel of o.
REQ-009 The block SHALL have port o_valid, output, 1, meaning o and o_sel are valid.
REQ-010 The block SHALL have port o_ready, input, 1, meaning the sink accepts o this cycle.

Function
REQ-011 A transfer SHALL occur on a channel when valid and ready are both 1 at a rising clk edge.
REQ-012 Output storage SHALL be a one-entry register with two states: EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-013 The register SHALL be loadable when state is EMPTY, or when state is FULL and o_ready=1 (drain and refill in the same cycle).
REQ-014 When the register is loadable and any i_valid bit is set, exactly one i_ready bit SHALL be set, selecting the arbitration winner; otherwise i_ready SHALL be 4'b0000.
REQ-015 i_ready SHALL depend combinationally on i_valid, o_ready, state and the arbitration pointer only, never on the data inputs.
REQ-016 On a transfer from channel k, the next cycle SHALL show o=ik, o_sel=k, o_valid=1, giving a latency of 1 cycle.
REQ-017 In FULL with o_ready=0, o, o_sel and o_valid SHALL hold, and i_ready SHALL be 0.
REQ-018 In FULL with o_ready=1 and no i_valid bit set, the state SHALL return to EMPTY.
REQ-019 Round-robin arbitration SHALL use a 2-bit pointer holding the last granted index, and SHALL search from pointer+1 upward, wrapping modulo 4.
REQ-020 The pointer SHALL update only on an input transfer; idle cycles and stalls SHALL leave it unchanged.
REQ-021 When the pointer is 3, the search SHALL wrap to start at channel 0.
REQ-022 With all four channels valid continuously and o_ready=1, the block SHALL sustain one word per cycle in grant order 0,1,2,3,0,...

Reset
REQ-023 While rst=1 at a clk edge, the state SHALL be EMPTY, o_valid=0, o={WIDTH{1'b0}}, o_sel=2'b00 and pointer=2'b11.
REQ-024 During reset, i_ready SHALL be 4'b0000.
REQ-025 A word held in the register when reset is asserted SHALL be discarded.

Configuration
REQ-026 With macro ARB_MUX_RR_EN defined, arbitration SHALL be round-robin per REQ-019 to REQ-022.
REQ-027 Without ARB_MUX_RR_EN, arbitration SHALL be fixed priority with ch0 > ch1 > ch2 > ch3; the pointer SHALL NOT be implemented; all other behaviour SHALL be unchanged.

Structure
REQ-028 Package arb_mux_pkg SHALL hold the constants CH_NUM=4 and SEL_W=2, typedef sel_t (logic [SEL_W-1:0]), and the state enum (EMPTY, FULL).
REQ-029 The grant logic SHALL be implemented as sub-module rr_arbiter_4, with inputs req[3:0], ptr and en, and output a one-hot gnt[3:0]; it SHALL contain the ARB_MUX_RR_EN selection.

Verification
REQ-030 Reset: with rst=1 for 2 cycles and i_valid=4'b1111 -> o_valid=0, o=0, o_sel=0 and i_ready=0 throughout.
REQ-031 Single word: i1=16'hBEEF with i_valid=4'b0010 for 1 cycle and o_ready=1 -> next cycle o=16'hBEEF, o_sel=1, o_valid=1; the cycle after that, o_valid=0.
REQ-032 Fairness (RR build): i_valid=4'b1111 held, i0..i3 = 16'h000k + transfer count, o_ready=1 -> o_sel sequence 0,1,2,3,0,1,2,3 with no idle cycles.
REQ-033 Back-pressure: the output is FULL with o=16'h1234, and o_ready=0 for 3 cycles -> o is held, i_ready=0; on o_ready=1 the next granted word appears the next cycle with none lost or duplicated.
REQ-034 Wrap and skip (RR build): the pointer is 2 after a ch2 grant, then i_valid=4'b1001 -> ch3 is granted, then ch0; i_valid=4'b0101 after a ch0 grant -> ch2 is granted.
REQ-035 Fixed priority (no macro) plus mid-operation reset: i_valid=4'b1111 held -> o_sel is always 0; asserting rst while FULL -> the next cycle o_valid=0, and after release ch0 is granted first.
